tff_bank_multi_mode: RTL and testbench

//  - WIDTH-bit bank of independent flip-flops; parametrised successor of the single-bit
//    x^y-driven toggle flip-flop.
//  - One global mode selects the per-bit next-state rule: T (x^y), D, JK or SR.
//  - Adds enable, a synchronous clear, a per-bit change strobe, a saturating

---
 rtl/tff_bank_multi_mode.sv | 130 +++++++++++++
 tb/tb_tff_bank_multi_mode.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_multi_mode.sv
// WIDTH-bit flip-flop bank with a global T/D/JK/SR rule, change strobe,
// saturating changed-bit counter and a sticky SR-illegal flag.
module tff_bank_multi_mode #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] cnt,
  output logic             sr_err
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_T  = 2'b00,
    MODE_D  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sr_err_q;
  logic             sr_err_d;
  logic             sr_illegal;
  logic [WIDTH-1:0] diff;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_sat;

  assign mode_s = mode_e'(mode);

  // Per-bit next-state rule; every channel follows the same global mode.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic nxt;
      always_comb begin
        nxt = a_q[gi];
        case (mode_s)
          MODE_T:  nxt = a_q[gi] ^ (x[gi] ^ y[gi]);
          MODE_D:  nxt = x[gi];
          MODE_JK: begin
            case ({x[gi], y[gi]})
              2'b01:   nxt = 1'b0;
              2'b10:   nxt = 1'b1;
              2'b11:   nxt = ~a_q[gi];
              default: nxt = a_q[gi];
            endcase
          end
          MODE_SR: begin
            case ({x[gi], y[gi]})
              2'b01:   nxt = 1'b0;
              2'b10:   nxt = 1'b1;
              default: nxt = a_q[gi];
            endcase
          end
          default: nxt = a_q[gi];
        endcase
      end
      assign a_d[gi] = nxt;
    end
  endgenerate

  assign sr_illegal = (mode_s == MODE_SR) && (|(x & y));
  assign diff       = a_d ^ a_q;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
  end

  // Sum is wide enough that it cannot wrap before the clamp is applied.
  assign sum     = SUM_W'(cnt_q) + SUM_W'(pc);
  assign cnt_sat = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_comb begin
    chg_d    = '0;
    cnt_d    = cnt_q;
    sr_err_d = sr_err_q;
    if (sclr) begin
      cnt_d    = '0;
      sr_err_d = 1'b0;
    end else if (en) begin
      chg_d    = diff;
      cnt_d    = cnt_sat;
      sr_err_d = sr_err_q | sr_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      chg_q    <= '0;
      cnt_q    <= '0;
      sr_err_q <= 1'b0;
    end else begin
      if (sclr) begin
        a_q <= '0;
      end else if (en) begin
        a_q <= a_d;
      end
      chg_q    <= chg_d;
      cnt_q    <= cnt_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign A      = a_q;
  assign chg    = chg_q;
  assign cnt    = cnt_q;
  assign sr_err = sr_err_q;

endmodule

// File: tb/tb_tff_bank_multi_mode.sv
// Bench for tff_bank_multi_mode: vector table, saturation and async-reset
// sequences, then randomized traffic against a behavioural model.
module tb_tff_bank_multi_mode;

  logic       clk;
  logic       reset;
  logic       en;
  logic       sclr;
  logic [1:0] mode;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] a8, chg8, a4, chg4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;
  logic       err8, err4;

  int checks = 0;
  int errors = 0;

  tff_bank_multi_mode #(.WIDTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .x(x), .y(y),
    .A(a8), .chg(chg8), .cnt(cnt8), .sr_err(err8)
  );

  tff_bank_multi_mode #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .x(x), .y(y),
    .A(a4), .chg(chg4), .cnt(cnt4), .sr_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sclr;
    logic       en;
    logic [1:0] mode;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] e_a;
    logic [3:0] e_chg;
    logic [7:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic e, input logic [1:0] m,
                              input logic [3:0] xi, input logic [3:0] yi,
                              input logic [3:0] ea, input logic [3:0] ec,
                              input logic [7:0] en_cnt, input logic ee);
    vec_t v;
    v.sclr = s; v.en = e; v.mode = m; v.x = xi; v.y = yi;
    v.e_a = ea; v.e_chg = ec; v.e_cnt = en_cnt; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: flip-flop rules written as a truth table of the four modes.
  function automatic logic [3:0] ref_next(input logic [1:0] m, input logic [3:0] q,
                                          input logic [3:0] a, input logic [3:0] b);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      if (m == 2'd0)      n[i] = (q[i] + a[i] + b[i]) % 2;
      else if (m == 2'd1) n[i] = a[i];
      else if (a[i] && b[i]) n[i] = (m == 2'd2) ? !q[i] : q[i];
      else if (a[i])      n[i] = 1'b1;
      else if (b[i])      n[i] = 1'b0;
      else                n[i] = q[i];
    end
    return n;
  endfunction

  function automatic int sat_add(input int c, input int d, input int maxv);
    return (c + d > maxv) ? maxv : c + d;
  endfunction

  initial begin
    int m_a, m_c8, m_c4, m_err, nx, nchg;

    reset = 1'b0; en = 1'b1; sclr = 1'b0; mode = 2'd0; x = 4'hF; y = 4'hF;
    repeat (3) step();
    $display("reset held: A=%h chg=%h cnt=%0d err=%b", a8, chg8, cnt8, err8);
    chk("reset_A", a8, 0);
    chk("reset_chg", chg8, 0);
    chk("reset_cnt", cnt8, 0);
    chk("reset_err", err8, 0);
    reset = 1'b1;

    // mode: 0=T 1=D 2=JK 3=SR
    vecs.push_back(mk(0, 1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0101, 2, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0011, 4'b1100, 4'b1100, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0011, 4'b0000, 4'b1100, 4, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 4'b0011, 4'b1100, 4'b1100, 6, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1010, 4'b1010, 4'b1100, 4'b0000, 6, 0));
    vecs.push_back(mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 2, 4'b1100, 4'b1010, 4'b1100, 4'b1100, 2, 0));
    vecs.push_back(mk(0, 1, 2, 4'b1100, 4'b1010, 4'b0100, 4'b1000, 3, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 1, 3, 4'b0011, 4'b0001, 4'b0011, 4'b0010, 2, 1));
    vecs.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4, 1));
    vecs.push_back(mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4, 1));
    vecs.push_back(mk(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4, 0));
    vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4, 0));
    vecs.push_back(mk(0, 0, 3, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4, 0));
    vecs.push_back(mk(1, 1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      sclr = vecs[i].sclr; en = vecs[i].en; mode = vecs[i].mode;
      x = vecs[i].x; y = vecs[i].y;
      step();
      $display("vec %0d: sclr=%b en=%b mode=%0d x=%b y=%b -> A=%b chg=%b cnt=%0d err=%b",
               i, sclr, en, mode, x, y, a8, chg8, cnt8, err8);
      chk($sformatf("vec%0d_A", i), a8, vecs[i].e_a);
      chk($sformatf("vec%0d_chg", i), chg8, vecs[i].e_chg);
      chk($sformatf("vec%0d_cnt", i), cnt8, vecs[i].e_cnt);
      chk($sformatf("vec%0d_err", i), err8, vecs[i].e_err);
    end

    // Saturation on the 4-bit counter, 8-bit counter keeps climbing.
    sclr = 1'b0; en = 1'b1; mode = 2'd1; y = 4'h0;
    for (int k = 0; k < 6; k++) begin
      int e4;
      x = (k % 2 == 0) ? 4'hF : 4'h0;
      step();
      e4 = sat_add(4 * k, 4, 15);
      $display("sat %0d: x=%b chg=%b cnt4=%0d cnt8=%0d", k, x, chg4, cnt4, cnt8);
      chk("sat_cnt4", cnt4, e4);
      chk("sat_chg4", chg4, 4'hF);
      chk("sat_cnt8", cnt8, 4 * (k + 1));
    end

    // Asynchronous reset asserted between edges.
    x = 4'hF; mode = 2'd1;
    step();
    #2 reset = 1'b0;
    #1;
    $display("async reset: A=%b chg=%b cnt8=%0d cnt4=%0d", a8, chg8, cnt8, cnt4);
    chk("async_A", a8, 0);
    chk("async_cnt8", cnt8, 0);
    chk("async_cnt4", cnt4, 0);
    chk("async_chg", chg8, 0);
    step();
    chk("async_hold_A", a8, 0);
    reset = 1'b1; mode = 2'd0; x = 4'b0101; y = 4'b0000;
    step();
    $display("release: A=%b chg=%b cnt=%0d", a8, chg8, cnt8);
    chk("release_A", a8, 4'b0101);
    chk("release_chg", chg8, 4'b0101);
    chk("release_cnt", cnt8, 2);

    // Randomized traffic against the model.
    sclr = 1'b1; en = 1'b0;
    step();
    m_a = 0; m_c8 = 0; m_c4 = 0; m_err = 0;
    for (int k = 0; k < 400; k++) begin
      sclr = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 4) != 0);
      mode = 2'($urandom_range(0, 3));
      x    = 4'($urandom);
      y    = 4'($urandom);
      if (sclr) begin
        m_a = 0; nchg = 0; m_c8 = 0; m_c4 = 0; m_err = 0;
      end else if (en) begin
        nx   = ref_next(mode, 4'(m_a), x, y);
        nchg = $countones(4'(nx ^ m_a));
        m_c8 = sat_add(m_c8, nchg, 255);
        m_c4 = sat_add(m_c4, nchg, 15);
        if (mode == 2'd3 && (x & y) != 0) m_err = 1;
        nchg = nx ^ m_a;
        m_a  = nx;
      end else begin
        nchg = 0;
      end
      step();
      $display("rnd %0d: sclr=%b en=%b mode=%0d x=%b y=%b -> A=%b chg=%b cnt8=%0d cnt4=%0d err=%b",
               k, sclr, en, mode, x, y, a8, chg8, cnt8, cnt4, err8);
      chk("rnd_A", a8, m_a);
      chk("rnd_chg", chg8, nchg);
      chk("rnd_cnt8", cnt8, m_c8);
      chk("rnd_cnt4", cnt4, m_c4);
      chk("rnd_err", err8, m_err);
      chk("rnd_A4", a4, m_a);
      chk("rnd_err4", err4, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
